// File: rtl/ppu_frame_writer_if.sv
// ----------------------------------------------------------------------------
// ppu_frame_writer_if
//
// Groups the signals between the PPU pixel pipe, the frame writer and the
// frame-buffer RAM.
//
// Handshake semantics:
//   PX_valid qualifies PX_OUT in the same cycle. There is no ready or
//   backpressure path. A pixel the writer cannot use is dropped, not stalled.
//   FB_WR is a single-cycle write strobe. FB_ADDR and FB_DATA are meaningful
//   only while FB_WR is high. The RAM must accept one write on every cycle.
//
// Signals:
//   PX_OUT     [1:0]  pixel colour index from the PPU
//   PX_valid          pixel qualifier
//   PPU_MODE   [1:0]  0=H_BLANK 1=V_BLANK 2=SCAN 3=DRAW
//   BGP        [7:0]  background palette register
//   FB_WR             write strobe to the frame buffer
//   FB_ADDR   [12:0]  frame-buffer byte address
//   FB_DATA    [7:0]  four packed pixels, first pixel in [7:6]
//   FRAME_DONE        one-cycle pulse on V_BLANK entry
//   LINE_OVF          sticky pixel-dropped flag
//   CUR_LINE   [7:0]  line currently being written
//
// Modports:
//   master  the PPU / test side (drives pixels, observes frame-buffer writes)
//   slave   the frame writer
// ----------------------------------------------------------------------------
interface ppu_frame_writer_if;
    logic [1:0]  PX_OUT;
    logic        PX_valid;
    logic [1:0]  PPU_MODE;
    logic [7:0]  BGP;
    logic        FB_WR;
    logic [12:0] FB_ADDR;
    logic [7:0]  FB_DATA;
    logic        FRAME_DONE;
    logic        LINE_OVF;
    logic [7:0]  CUR_LINE;

    modport master (
        output PX_OUT, PX_valid, PPU_MODE, BGP,
        input  FB_WR, FB_ADDR, FB_DATA, FRAME_DONE, LINE_OVF, CUR_LINE
    );

    modport slave (
        input  PX_OUT, PX_valid, PPU_MODE, BGP,
        output FB_WR, FB_ADDR, FB_DATA, FRAME_DONE, LINE_OVF, CUR_LINE
    );
endinterface

// File: rtl/ppu_frame_writer.sv
// ----------------------------------------------------------------------------
// ppu_frame_writer
//
// Consumes the PPU pixel stream during DRAW mode. It packs four 2-bit shades
// per byte and writes the bytes into a LINE_PX x FRAME_LINES frame buffer
// (LINE_PX/4 bytes per line). PPU_MODE transitions mark the line boundaries
// (DRAW->H_BLANK) and the frame boundaries (entry into V_BLANK).
//
// Optional feature:
//   PPU_FW_PALETTE_EN  When defined, each pixel is mapped through BGP:
//                      shade = BGP[2*px+1:2*px]. When undefined, the raw
//                      PX_OUT value is stored and BGP is ignored.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   bus          ppu_frame_writer_if.slave (pixel input, frame-buffer output)
//   dbg_state_o  current FSM state
//                0=LINE 1=FLUSH 2=HBL 3=FULL 4=VBL
//
// Write timing:
//   - The 4th pixel of a byte, sampled at edge N, produces FB_WR during
//     cycle N+1.
//   - A partial byte at the end of a line is written from the FLUSH state.
//     It appears one cycle after the H_BLANK edge is seen.
// ----------------------------------------------------------------------------
module ppu_frame_writer #(
    parameter logic [12:0] FB_BASE     = 13'h0000,
    parameter int          LINE_PX     = 160,
    parameter int          FRAME_LINES = 144
) (
    input  logic                 clk,
    input  logic                 rst,
    ppu_frame_writer_if.slave    bus,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        ST_LINE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_HBL   = 3'd2,
        ST_FULL  = 3'd3,
        ST_VBL   = 3'd4
    } state_t;

    localparam logic [1:0]  MODE_HBL  = 2'd0;
    localparam logic [1:0]  MODE_VBL  = 2'd1;
    localparam logic [1:0]  MODE_SCAN = 2'd2;
    localparam logic [1:0]  MODE_DRAW = 2'd3;

    localparam logic [7:0]  LINE_PX_W     = 8'(LINE_PX);
    localparam logic [7:0]  FRAME_LINES_W = 8'(FRAME_LINES);
    localparam logic [12:0] LINE_BYTES    = 13'(LINE_PX / 4);

    state_t      state_q, state_d;
    logic [1:0]  mode_q;
    logic [7:0]  x_q, x_d;
    logic [1:0]  px_cnt_q, px_cnt_d;
    logic [5:0]  acc_q, acc_d;
    logic [7:0]  line_q, line_d;
    logic        wr_q, wr_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic [1:0]  shade;
    logic        vbl_edge;
    logic        hbl_edge;
    logic        px_take;
    logic [12:0] byte_addr;

`ifdef PPU_FW_PALETTE_EN
    assign shade = bus.BGP[{bus.PX_OUT, 1'b0} +: 2];
`else
    assign shade = bus.PX_OUT;
    // BGP stays on the port list for the palette build only.
    logic unused_bgp;
    assign unused_bgp = ^bus.BGP;
`endif

    // Mode edges are taken against the previous cycle's mode.
    assign vbl_edge = (mode_q != MODE_VBL) && (bus.PPU_MODE == MODE_VBL);
    assign hbl_edge = (mode_q == MODE_DRAW) && (bus.PPU_MODE == MODE_HBL);
    assign px_take  = bus.PX_valid && (bus.PPU_MODE == MODE_DRAW) &&
                      (state_q == ST_LINE);

    // Byte address of the byte that holds pixel x. It wraps at 13 bits.
    assign byte_addr = FB_BASE + (13'(line_q) * LINE_BYTES) + {7'd0, x_q[7:2]};

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        px_cnt_d = px_cnt_q;
        acc_d    = acc_q;
        line_d   = line_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;

        if (vbl_edge) begin
            // Frame end takes priority in every state. Any half-built byte
            // is abandoned; a normal line was already flushed at H_BLANK.
            done_d   = 1'b1;
            line_d   = 8'd0;
            x_d      = 8'd0;
            px_cnt_d = 2'd0;
            acc_d    = 6'd0;
            state_d  = ST_VBL;
        end else begin
            case (state_q)
                ST_LINE: begin
                    if (hbl_edge) begin
                        if (px_cnt_q != 2'd0) begin
                            state_d = ST_FLUSH;
                        end else begin
                            x_d     = 8'd0;
                            line_d  = line_q + 8'd1;
                            state_d = ST_HBL;
                        end
                    end else if (px_take) begin
                        if (x_q == LINE_PX_W) begin
                            ovf_d = 1'b1;
                        end else begin
                            acc_d    = {acc_q[3:0], shade};
                            x_d      = x_q + 8'd1;
                            px_cnt_d = px_cnt_q + 2'd1;
                            if (px_cnt_q == 2'd3) begin
                                wr_d   = 1'b1;
                                addr_d = byte_addr;
                                data_d = {acc_q, shade};
                            end
                        end
                    end
                end

                ST_FLUSH: begin
                    // Held pixels sit in the low bits of acc_q. Left-justify
                    // them and pad the unfilled positions with zero.
                    wr_d   = 1'b1;
                    addr_d = byte_addr;
                    case (px_cnt_q)
                        2'd1:    data_d = {acc_q[1:0], 6'd0};
                        2'd2:    data_d = {acc_q[3:0], 4'd0};
                        default: data_d = {acc_q[5:0], 2'd0};
                    endcase
                    px_cnt_d = 2'd0;
                    acc_d    = 6'd0;
                    x_d      = 8'd0;
                    line_d   = line_q + 8'd1;
                    state_d  = ST_HBL;
                end

                ST_HBL: begin
                    if (bus.PPU_MODE == MODE_DRAW) begin
                        if (line_q == FRAME_LINES_W) begin
                            ovf_d   = 1'b1;
                            state_d = ST_FULL;
                        end else begin
                            state_d = ST_LINE;
                        end
                    end
                end

                ST_FULL: begin
                    // Extra lines past the frame are ignored until V_BLANK.
                end

                ST_VBL: begin
                    if (bus.PPU_MODE != MODE_VBL) begin
                        state_d = ST_HBL;
                    end
                end

                default: state_d = ST_HBL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HBL;
            mode_q   <= MODE_SCAN;
            x_q      <= 8'd0;
            px_cnt_q <= 2'd0;
            acc_q    <= 6'd0;
            line_q   <= 8'd0;
            wr_q     <= 1'b0;
            addr_q   <= 13'd0;
            data_q   <= 8'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= bus.PPU_MODE;
            x_q      <= x_d;
            px_cnt_q <= px_cnt_d;
            acc_q    <= acc_d;
            line_q   <= line_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.FB_WR      = wr_q;
    assign bus.FB_ADDR    = addr_q;
    assign bus.FB_DATA    = data_q;
    assign bus.FRAME_DONE = done_q;
    assign bus.LINE_OVF   = ovf_q;
    assign bus.CUR_LINE   = line_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ppu_frame_writer.sv
// ----------------------------------------------------------------------------
// tb_ppu_frame_writer
//
// Randomised line and frame stimulus for ppu_frame_writer. A line-level
// reference model runs after each line. It takes the list of pixels the
// driver presented while the writer was in LINE, and it produces the expected
// byte writes: addresses, packed data and the cycle of each strobe. These are
// compared with the writes the monitor captured.
// ----------------------------------------------------------------------------
module tb_ppu_frame_writer;

    localparam logic [12:0] TB_FB_BASE = 13'h0000;
    localparam int          TB_LINE_PX = 160;
    localparam int          TB_LINES   = 144;

    localparam logic [1:0] M_HBL  = 2'd0;
    localparam logic [1:0] M_VBL  = 2'd1;
    localparam logic [1:0] M_SCAN = 2'd2;
    localparam logic [1:0] M_DRAW = 2'd3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ppu_frame_writer_if bus ();

    ppu_frame_writer #(
        .FB_BASE     (TB_FB_BASE),
        .LINE_PX     (TB_LINE_PX),
        .FRAME_LINES (TB_LINES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, got running expected finished");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [20:0] exp_q[$];      // {addr, data}
    int          exp_cyc_q[$];
    logic [20:0] obs_q[$];
    int          obs_cyc_q[$];
    int          done_cnt = 0;

    // Pixels presented while the writer is in LINE, with their drive cycle.
    logic [1:0]  line_px_q[$];
    int          line_cyc_q[$];
    logic [7:0]  line_bgp;

    // Model state
    int          m_line = 0;
    logic        m_ovf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.FRAME_DONE) done_cnt++;
        if (bus.FB_WR) begin
            obs_q.push_back({bus.FB_ADDR, bus.FB_DATA});
            obs_cyc_q.push_back(cyc);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] shade_of(input logic [1:0] px, input logic [7:0] bgp);
        logic [7:0] t;
`ifdef PPU_FW_PALETTE_EN
        t = bgp >> (2 * px);
`else
        t = {6'd0, px} | (bgp & 8'h00);
`endif
        return t[1:0];
    endfunction

    task automatic model_line(input int hbl_cyc);
        int          n;
        int          kept;
        logic [7:0]  data;
        logic [12:0] addr;
        n = line_px_q.size();
        if (m_line == TB_LINES) begin
            // The frame is already complete. DRAW raises the overflow flag
            // and every pixel of this line is discarded.
            m_ovf = 1'b1;
        end else begin
            kept = (n > TB_LINE_PX) ? TB_LINE_PX : n;
            if (n > TB_LINE_PX) m_ovf = 1'b1;
            for (int b = 0; b * 4 < kept; b++) begin
                data = 8'd0;
                for (int k = 0; k < 4; k++) begin
                    if (b * 4 + k < kept)
                        data = data | (8'(shade_of(line_px_q[b * 4 + k], line_bgp)) << (6 - 2 * k));
                end
                addr = 13'((int'(TB_FB_BASE) + m_line * (TB_LINE_PX / 4) + b) % 8192);
                exp_q.push_back({addr, data});
                if (b * 4 + 3 < kept) exp_cyc_q.push_back(line_cyc_q[b * 4 + 3] + 1);
                else                  exp_cyc_q.push_back(hbl_cyc + 2);
            end
            m_line++;
        end
        line_px_q.delete();
        line_cyc_q.delete();
    endtask

    task automatic compare_writes();
        int n;
        check("wr_count", 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("wr_addr",  32'(obs_q[i][20:8]), 32'(exp_q[i][20:8]));
            check("wr_data",  32'(obs_q[i][7:0]),  32'(exp_q[i][7:0]));
            check("wr_cycle", 32'(obs_cyc_q[i]),   32'(exp_cyc_q[i]));
        end
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 random pixels, 1 ramp 0,1,2,3..., 2 constant cval
    task automatic drive_line(input int n, input int kind, input logic [1:0] cval, input logic [7:0] bgp);
        logic [1:0] v;
        int         hbl_cyc;
        line_bgp     = bgp;
        bus.BGP      = bgp;
        // Junk pixels outside DRAW must be ignored.
        bus.PPU_MODE = M_SCAN;
        bus.PX_valid = 1'($urandom_range(0, 1));
        bus.PX_OUT   = 2'($urandom);
        tick();
        tick();
        // First DRAW cycle: the writer is still in HBL, so this pixel is ignored.
        bus.PPU_MODE = M_DRAW;
        bus.PX_valid = 1'($urandom_range(0, 1));
        bus.PX_OUT   = 2'($urandom);
        tick();
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.PX_valid = 1'b0;
                bus.PX_OUT   = 2'($urandom);
                tick();
            end
            case (kind)
                0:       v = 2'($urandom);
                1:       v = 2'(i % 4);
                default: v = cval;
            endcase
            bus.PX_valid = 1'b1;
            bus.PX_OUT   = v;
            line_px_q.push_back(v);
            line_cyc_q.push_back(cyc);
            tick();
        end
        bus.PPU_MODE = M_HBL;
        bus.PX_valid = 1'($urandom_range(0, 1));
        bus.PX_OUT   = 2'($urandom);
        hbl_cyc      = cyc;
        tick();
        tick();
        tick();
        model_line(hbl_cyc);
        compare_writes();
        check("cur_line", 32'(bus.CUR_LINE), 32'(m_line));
        check("line_ovf", 32'(bus.LINE_OVF), 32'(m_ovf));
    endtask

    task automatic do_vblank();
        int d0;
        d0           = done_cnt;
        bus.PPU_MODE = M_VBL;
        bus.PX_valid = 1'($urandom_range(0, 1));
        tick();
        tick();
        tick();
        tick();
        m_line = 0;
        check("frame_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("vbl_cur_line", 32'(bus.CUR_LINE), 32'd0);
        check("vbl_no_writes", 32'(obs_q.size()), 32'd0);
        bus.PPU_MODE = M_SCAN;
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fb_wr"},      32'(bus.FB_WR),      32'd0);
        check({tag, "_fb_addr"},    32'(bus.FB_ADDR),    32'd0);
        check({tag, "_fb_data"},    32'(bus.FB_DATA),    32'd0);
        check({tag, "_frame_done"}, 32'(bus.FRAME_DONE), 32'd0);
        check({tag, "_line_ovf"},   32'(bus.LINE_OVF),   32'd0);
        check({tag, "_cur_line"},   32'(bus.CUR_LINE),   32'd0);
        check({tag, "_state_hbl"},  32'(dbg_state),      32'd2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.PX_OUT   = 2'd0;
        bus.PX_valid = 1'b0;
        bus.PPU_MODE = M_SCAN;
        bus.BGP      = 8'hE4;
        rst          = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Frame 1: palette ramp, partial flush, full line, random line.
        drive_line(4, 1, 2'd0, 8'hE4);
`ifdef PPU_FW_PALETTE_EN
        drive_line(4, 1, 2'd0, 8'h1B);
`endif
        drive_line(6, 2, 2'd1, 8'hE4);
        drive_line(TB_LINE_PX, 2, 2'd3, 8'hE4);
        drive_line(37, 0, 2'd0, 8'($urandom));
        drive_line(0, 0, 2'd0, 8'hE4);
        do_vblank();

        // Frame 2: full line at the base, then an overflowing line.
        drive_line(TB_LINE_PX, 2, 2'd3, 8'hE4);
        drive_line(TB_LINE_PX + 4, 0, 2'd0, 8'($urandom));
        drive_line(21, 0, 2'd0, 8'($urandom));
        check("ovf_sticky", 32'(bus.LINE_OVF), 32'd1);
        do_vblank();
        check("ovf_sticky_vbl", 32'(bus.LINE_OVF), 32'd1);

        // Reset in the middle of a line after three pixels.
        bus.PPU_MODE = M_DRAW;
        bus.PX_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.PX_valid = 1'b1;
            bus.PX_OUT   = 2'($urandom);
            tick();
        end
        rst          = 1'b1;
        bus.PX_valid = 1'b0;
        bus.PPU_MODE = M_SCAN;
        tick();
        check_reset_values("midline_rst");
        check("midline_rst_no_wr", 32'(obs_q.size()), 32'd0);
        rst = 1'b0;
        m_line = 0;
        m_ovf  = 1'b0;
        line_px_q.delete();
        line_cyc_q.delete();
        tick();

        // Frame 3: a full frame of short random lines, then one extra line.
        for (int l = 0; l < TB_LINES; l++)
            drive_line($urandom_range(0, 24), 0, 2'd0, 8'($urandom));
        check("ovf_before_extra", 32'(bus.LINE_OVF), 32'd0);
        drive_line(8, 0, 2'd0, 8'($urandom));
        check("extra_line_cur", 32'(bus.CUR_LINE), 32'(TB_LINES));
        do_vblank();

        // Next frame starts again at the base address.
        drive_line(12, 0, 2'd0, 8'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_frame_writer.md
# ppu_frame_writer

Consumer of the PPU pixel stream. Samples 2-bit pixels (PX_OUT/PX_valid) during DRAW mode, optionally maps them through the BGP palette, packs four pixels per byte, and writes them into a 160x144 frame buffer (5760 bytes, 40 bytes per line). Sits between PPU3 and the frame-buffer RAM read by the video scan-out logic; tracks line and frame boundaries from PPU_MODE.

## Interface
Parameters:
- FB_BASE, 13'h0000, frame-buffer byte address of pixel (0,0)
- LINE_PX, 160, visible pixels per line (multiple of 4)
- FRAME_LINES, 144, visible lines per frame

Ports:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- PX_OUT  in  2  pixel colour index from PPU
- PX_valid  in  1  pixel qualifier
- PPU_MODE  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW
- BGP  in  8  background palette (FF47)
- FB_WR  out  1  one-cycle write strobe
- FB_ADDR  out  13  byte address
- FB_DATA  out  8  packed pixels, first pixel in [7:6], fourth in [1:0]
- FRAME_DONE  out  1  one-cycle pulse on V_BLANK entry
- LINE_OVF  out  1  sticky: pixel dropped (line >LINE_PX px or frame >FRAME_LINES lines)
- CUR_LINE  out  8  line currently being written

## Operation
- Accepted pixel: PX_valid=1 and PPU_MODE==DRAW in the same cycle and state LINE. Others ignored (not counted).
- Shade: BGP[2*px+1 : 2*px] (see Configuration). Shifted into a 6-bit accumulator; px_cnt[1:0] counts pixels in current byte; x (8 bit) counts pixels in line.
- Fourth pixel of a byte: registered write next cycle; FB_ADDR = FB_BASE + CUR_LINE*40 + x/4 (13-bit, wraps mod 2^13).
- Pixel arriving with x == LINE_PX: dropped, LINE_OVF set.
- States:
  - LINE: accept pixels. On mode edge DRAW->H_BLANK: if px_cnt!=0 go FLUSH, else go HBL (x<=0, CUR_LINE++).
  - FLUSH: one cycle; write partial byte, unfilled low positions padded with 2'b00; x<=0, CUR_LINE++; go HBL.
  - HBL: wait for PPU_MODE==DRAW -> LINE. If CUR_LINE==FRAME_LINES and DRAW arrives: go FULL, set LINE_OVF.
  - FULL: discard all pixels.
  - Any state, mode edge (prev!=V_BLANK, now V_BLANK): FRAME_DONE pulse, CUR_LINE<=0, x<=0, px_cnt<=0, go VBL. Pending partial byte is discarded (lines are flushed at H_BLANK first).
  - VBL: leave to HBL when PPU_MODE != V_BLANK.
- Mode edges detected against a registered copy of PPU_MODE (reset value SCAN).
- LINE_OVF cleared only by rst.

## Timing
- Reset values: FB_WR=0, FB_ADDR=0, FB_DATA=0, FRAME_DONE=0, LINE_OVF=0, CUR_LINE=0; state HBL, x=0, px_cnt=0, prev mode=SCAN.
- Latency: 4th pixel sampled at edge N -> FB_WR/FB_ADDR/FB_DATA valid during cycle N+1, FB_WR low at N+2 unless another write.
- Max one write per cycle; back-to-back writes legal (4 pixels in 4 consecutive cycles produce strobes 4 cycles apart).
- Simultaneous 4th pixel and DRAW->H_BLANK edge: pixel accepted, full byte written, no FLUSH.
- Simultaneous V_BLANK entry and write strobe: write completes (registered), FRAME_DONE asserted same cycle.
- FLUSH write appears one cycle after the H_BLANK edge is seen (two cycles after mode change).
- rst mid-line: all state cleared next edge; no partial write emitted.

## Configuration
- PPU_FW_PALETTE_EN defined: shade = BGP-mapped value as above.
- Undefined: shade = raw PX_OUT; BGP input unused (kept on port list).

## Test plan
- Palette: BGP=8'hE4, PX_OUT sequence 0,1,2,3 in DRAW -> one write, FB_ADDR=0, FB_DATA=8'h1B; with BGP=8'h1B (macro on) FB_DATA=8'hE4.
- Full line: 160 pixels of 3 on line 0 -> 40 writes, addresses 0..39, data 8'hFF (BGP=E4); then line 1 first write at address 40, CUR_LINE=1.
- Partial flush: 6 pixels of 1 then DRAW->H_BLANK -> writes FB_DATA=8'h55 at 0, then 8'h50 at 1 in FLUSH; LINE_OVF=0.
- Overflow: 164 pixels on one line -> 40 writes, last 4 dropped, LINE_OVF=1 sticky until rst.
- Frame: 144 lines then V_BLANK -> FRAME_DONE one cycle, CUR_LINE=0; next frame first write at FB_BASE; a 145th DRAW line before V_BLANK sets LINE_OVF with no writes.
- Reset mid-line after 3 pixels -> no FB_WR, all outputs at reset values next cycle.
